// File: rtl/roll_column_buffer.sv
// roll_column_buffer
// Column store for the roll-mode display. Each slow-rate sample (value
// qualified by w_clk) is scaled to a screen row and written into a circular
// RAM with one entry per screen column. The scanner reads column x and gets
// the x-th oldest stored sample. Once every column holds a sample, the trace
// scrolls left by one column per new sample.
//
// Optional feature: define ROLL_HOLD_EN to make the hold input freeze the
// trace by dropping writes. When it is undefined, hold is ignored.
//
// Read latency: rd_req is sampled at edge N. rd_y, rd_blank and rd_valid
// become visible after edge N+1, which is two cycles after the request.
module roll_column_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 12,
    parameter int YW    = 9,
    parameter int Y_MAX = 479
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] value,
    input  logic          w_clk,
    input  logic          hold,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_blank,
    output logic          rd_valid,
    output logic          full,
    output logic [AW-1:0] wr_ptr
);

    localparam int          SHIFT   = DW - YW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
    localparam logic [YW-1:0] Y_MAX_W = YW'(Y_MAX);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } fill_state_e;

    // Fill tracking state
    fill_state_e   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;

    // Read pipeline state
    logic          req1_q;
    logic          blank1_q;
    logic [YW-1:0] ram_q;
    logic [YW-1:0] rd_y_q, rd_y_d;
    logic          rd_blank_q, rd_blank_d;
    logic          rd_valid_q, rd_valid_d;

    // Combinational helpers
    logic          wr_en_s;
    logic [YW-1:0] s_raw_s;
    logic [YW-1:0] s_clamp_s;
    logic [YW-1:0] row_s;
    logic [AW:0]   sum_s;
    logic [AW:0]   wrap_s;
    logic          blank_d;
    logic [AW-1:0] phys_s;

    // The RAM covers the whole address space so any AW-bit index is in range;
    // entries at DEPTH and above are never written or used for display.
    logic [YW-1:0] mem_q [0:(2**AW)-1];

`ifdef ROLL_HOLD_EN
    assign wr_en_s = w_clk & ~hold;
`else
    logic unused_hold_s;
    assign unused_hold_s = hold;
    assign wr_en_s       = w_clk;
`endif

    // Scale the incoming sample to a screen row, with sample 0 on the bottom row.
    always_comb begin
        s_raw_s = YW'(value >> SHIFT);
        if (s_raw_s > Y_MAX_W) begin
            s_clamp_s = Y_MAX_W;
        end else begin
            s_clamp_s = s_raw_s;
        end
        row_s = Y_MAX_W - s_clamp_s;
    end

    // Next write pointer, fill count and fill state for an accepted write.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        if (wr_en_s) begin
            if (wr_ptr_q == LAST_A) begin
                wr_ptr_d = {AW{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case (state_q)
                ST_EMPTY, ST_FILLING: begin
                    count_d = count_q + (AW+1)'(1);
                    if (count_d == DEPTH_W) begin
                        state_d = ST_FULL;
                        full_d  = 1'b1;
                    end else begin
                        state_d = ST_FILLING;
                        full_d  = 1'b0;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                    count_d = DEPTH_W;
                    full_d  = 1'b1;
                end
                default: begin
                    state_d  = ST_EMPTY;
                    wr_ptr_d = {AW{1'b0}};
                    count_d  = {(AW+1){1'b0}};
                    full_d   = 1'b0;
                end
            endcase
        end else begin
            state_d  = state_q;
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Map the requested column to a physical address. Once full, the oldest
    // sample sits at wr_ptr, so column x lives at (x + wr_ptr) mod DEPTH.
    always_comb begin
        sum_s = {1'b0, rd_x} + {1'b0, wr_ptr_q};
        if (full_q) begin
            if (sum_s >= DEPTH_W) begin
                wrap_s = sum_s - DEPTH_W;
            end else begin
                wrap_s = sum_s;
            end
        end else begin
            wrap_s = {1'b0, rd_x};
        end
        blank_d = (!full_q && ({1'b0, rd_x} >= count_q)) || ({1'b0, rd_x} >= DEPTH_W);
        if (blank_d) begin
            phys_s = {AW{1'b0}};
        end else begin
            phys_s = AW'(wrap_s);
        end
    end

    // Output stage: blank columns read as row 0.
    always_comb begin
        rd_valid_d = req1_q;
        rd_blank_d = blank1_q;
        if (blank1_q) begin
            rd_y_d = {YW{1'b0}};
        end else begin
            rd_y_d = ram_q;
        end
    end

    // Column RAM. The read and the write share the request edge, so a read
    // of the address being written returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_q[wr_ptr_q] <= row_s;
        end
        ram_q <= mem_q[phys_s];
    end

    // Fill FSM, write pointer and read pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            full_q     <= 1'b0;
            req1_q     <= 1'b0;
            blank1_q   <= 1'b1;
            rd_y_q     <= {YW{1'b0}};
            rd_blank_q <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            req1_q     <= rd_req;
            blank1_q   <= blank_d;
            rd_y_q     <= rd_y_d;
            rd_blank_q <= rd_blank_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_y     = rd_y_q;
    assign rd_blank = rd_blank_q;
    assign rd_valid = rd_valid_q;
    assign full     = full_q;
    assign wr_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_roll_column_buffer.sv
// Bench for roll_column_buffer (DEPTH=8). The reference model keeps the last
// DEPTH written rows oldest-first plus a total write count; reads are answered
// from that list and checked against the DUT two cycles later.
module tb_roll_column_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int YW    = 9;
    localparam int Y_MAX = 479;

    logic          clk;
    logic          rst;
    logic [DW-1:0] value;
    logic          w_clk;
    logic          hold;
    logic          rd_req;
    logic [AW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_blank;
    logic          rd_valid;
    logic          full;
    logic [AW-1:0] wr_ptr;

    roll_column_buffer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .YW(YW), .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .w_clk(w_clk), .hold(hold),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_blank(rd_blank),
        .rd_valid(rd_valid), .full(full), .wr_ptr(wr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit blank;
        int y;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_wr  = 0;
    int   hist[$];
    exp_t expq[$];

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int row_of(input int v);
        int s;
        s = v / 8;
        if (s > Y_MAX) s = Y_MAX;
        return Y_MAX - s;
    endfunction

    function automatic void model_read(input int x, output bit blank, output int y);
        if (x >= DEPTH || x >= hist.size()) begin
            blank = 1'b1;
            y     = 0;
        end else begin
            blank = 1'b0;
            y     = hist[x];
        end
    endfunction

    // One clock: apply inputs, advance the model at the edge, then compare.
    task automatic step(input bit r, input bit wc, input int v, input bit h,
                        input bit rq, input int x);
        exp_t e;
        bit   acc;
        rst = r; w_clk = wc; value = DW'(v); hold = h; rd_req = rq; rd_x = AW'(x);
`ifdef ROLL_HOLD_EN
        acc = wc && !h;
`else
        acc = wc;
`endif
        if (r) begin
            hist.delete();
            expq.delete();
            n_wr = 0;
        end else begin
            if (rq) begin
                model_read(x, e.blank, e.y);
                e.due = cyc + 2;
                expq.push_back(e);
            end
            if (acc) begin
                hist.push_back(row_of(v));
                if (hist.size() > DEPTH) void'(hist.pop_front());
                n_wr++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            chk("rst_valid", int'(rd_valid), 0);
            chk("rst_blank", int'(rd_blank), 1);
            chk("rst_y", int'(rd_y), 0);
        end else if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rd_valid", int'(rd_valid), 1);
            chk("rd_blank", int'(rd_blank), int'(e.blank));
            chk("rd_y", int'(rd_y), e.y);
        end else begin
            chk("rd_idle", int'(rd_valid), 0);
        end
        chk("full", int'(full), (n_wr >= DEPTH) ? 1 : 0);
        chk("wr_ptr", int'(wr_ptr), n_wr % DEPTH);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic wr(input int v);
        step(1'b0, 1'b1, v, 1'b0, 1'b0, 0);
    endtask

    task automatic rd(input int x);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, x);
    endtask

    initial begin
        bit  b;
        int  y;
        int  p0;
        rst = 1'b1; w_clk = 1'b0; value = '0; hold = 1'b0; rd_req = 1'b0; rd_x = '0;

        // Reset, then a read of an empty buffer.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        chk("lit_full_rst", int'(full), 0);
        chk("lit_wrptr_rst", int'(wr_ptr), 0);
        model_read(0, b, y);
        chk("pin_empty_blank", int'(b), 1);
        rd(0);
        idle(2);

        // Scaling: 0 -> 479, 4095 -> clamped -> 0, 800 -> 379.
        wr(0); wr(4095); wr(800);
        chk("pin_row0", hist[0], 479);
        chk("pin_row1", hist[1], 0);
        chk("pin_row2", hist[2], 379);
        model_read(3, b, y);
        chk("pin_x3_blank", int'(b), 1);
        for (int x = 0; x < 4; x++) rd(x);
        idle(2);

        // Fill past DEPTH and scroll.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) wr(i * 80);
        chk("lit_full", int'(full), 1);
        chk("lit_wrptr", int'(wr_ptr), 2);
        model_read(0, b, y);
        chk("pin_x0", y, 459);
        model_read(7, b, y);
        chk("pin_x7", y, 389);
        rd(0); rd(7);
        idle(2);

        // Same-cycle write and read of physical address 2: read-first.
        model_read(0, b, y);
        chk("pin_rw_old", y, 459);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1, 0);
        model_read(7, b, y);
        chk("pin_rw_new", y, 479);
        rd(7);
        idle(2);

        // Back-to-back reads, one per cycle.
        for (int x = 0; x < 8; x++) rd(x);
        idle(2);

        // Reset mid-fill with a read in flight.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) wr(i * 300);
        rd(1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1, 2);
        chk("lit_full_mid", int'(full), 0);
        chk("lit_wrptr_mid", int'(wr_ptr), 0);
        for (int x = 0; x < 8; x++) rd(x);
        idle(2);

`ifdef ROLL_HOLD_EN
        // Hold freezes writes; reads continue.
        for (int i = 0; i < 4; i++) wr(i * 500);
        p0 = int'(wr_ptr);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4000, 1'b1, 1'b1, i);
        chk("lit_hold_ptr", int'(wr_ptr), p0);
        step(1'b0, 1'b1, 100, 1'b0, 1'b0, 0);
        chk("lit_release_ptr", int'(wr_ptr), (p0 + 1) % DEPTH);
        idle(2);
`else
        p0 = 0;
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int v;
            case ($urandom_range(0, 3))
                0:       v = 0;
                1:       v = 4095;
                default: v = $urandom_range(0, 4095);
            endcase
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), v,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 15));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
